// File: rtl/simon_reg_bridge.sv
// Register bridge between the I2C slave byte streams and a SIMON round core.
// Define SIMON_READBACK_EN to make the KEY/BLK registers readable over the bus.
module simon_reg_bridge #(
  parameter int unsigned KEY_BYTES = 8,
  parameter int unsigned BLK_BYTES = 4,
  parameter logic [7:0]  ADDR_MASK = 8'h7F
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bus_addressed,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   core_rst,
  output logic                   core_mode,
  output logic [8*KEY_BYTES-1:0] core_key,
  output logic [8*BLK_BYTES-1:0] core_block,
  input  logic [8*BLK_BYTES-1:0] core_result,
  input  logic                   core_done,
  output logic                   irq
);

  localparam int unsigned KW = 8 * KEY_BYTES;
  localparam int unsigned BW = 8 * BLK_BYTES;

  typedef enum logic {
    P_IDLE,
    P_DATA
  } pstate_e;

  typedef enum logic [1:0] {
    C_IDLE,
    C_LOAD,
    C_RUN
  } cstate_e;

  pstate_e       p_q;
  cstate_e       c_q;
  logic [7:0]    ptr_q;
  logic          rdy_q;
  logic          mode_q;
  logic          crst_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [KW-1:0] key_q;
  logic [BW-1:0] blk_q;
  logic [BW-1:0] res_q;

  logic       rx_hs;
  logic       tx_hs;
  logic       wr_en;
  logic [7:0] ptr_inc;
  logic       is_key;
  logic       is_blk;
  logic       is_ctrl;
  logic       is_res;
  logic       is_stat;
  logic       go;
  logic       err_set;
  logic       err_clr;
  logic       stat_rd;
  logic [7:0] rd_byte;

  assign rx_hs   = rx_valid & rdy_q;
  assign tx_hs   = tx_valid & tx_ready;
  assign wr_en   = rx_hs & bus_addressed & (p_q == P_DATA);
  assign ptr_inc = (ptr_q + 8'd1) & ADDR_MASK;

  assign is_key  = {24'b0, ptr_q} < KEY_BYTES;
  assign is_blk  = (ptr_q[7:4] == 4'h2) &&
                   ({28'b0, ptr_q[3:0]} < BLK_BYTES);
  assign is_res  = (ptr_q[7:4] == 4'h5) &&
                   ({28'b0, ptr_q[3:0]} < BLK_BYTES);
  assign is_ctrl = ptr_q == 8'h40;
  assign is_stat = ptr_q == 8'h60;

  assign go      = wr_en & is_ctrl & rx_data[0] & ~busy_q;
  assign err_set = wr_en & busy_q &
                   (is_key | is_blk | (is_ctrl & rx_data[0]));
  assign err_clr = wr_en & is_ctrl & rx_data[2];
  assign stat_rd = tx_hs & is_stat;

  always_comb begin
    rd_byte = 8'hFF;
    unique case (1'b1)
      is_stat: rd_byte = {5'b0, err_q, done_q, busy_q};
      is_ctrl: rd_byte = {6'b0, mode_q, 1'b0};
      is_res: begin
        for (int i = 0; i < int'(BLK_BYTES); i++) begin
          if (ptr_q[3:0] == 4'(i)) rd_byte = res_q[8*i +: 8];
        end
      end
`ifdef SIMON_READBACK_EN
      is_key: begin
        for (int i = 0; i < int'(KEY_BYTES); i++) begin
          if (ptr_q[4:0] == 5'(i)) rd_byte = key_q[8*i +: 8];
        end
      end
      is_blk: begin
        for (int i = 0; i < int'(BLK_BYTES); i++) begin
          if (ptr_q[3:0] == 4'(i)) rd_byte = blk_q[8*i +: 8];
        end
      end
`endif
      default: rd_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= P_IDLE;
      c_q    <= C_IDLE;
      ptr_q  <= 8'h00;
      rdy_q  <= 1'b0;
      mode_q <= 1'b0;
      crst_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      key_q  <= '0;
      blk_q  <= '0;
      res_q  <= '0;
    end else begin
      rdy_q <= 1'b1;

      // A write beats a same-cycle read: the pointer moves only once.
      if (!bus_addressed) begin
        p_q <= P_IDLE;
      end else if (rx_hs && p_q == P_IDLE) begin
        ptr_q <= rx_data & ADDR_MASK;
        p_q   <= P_DATA;
      end else if (rx_hs || tx_hs) begin
        ptr_q <= ptr_inc;
      end

      if (wr_en && !busy_q) begin
        for (int i = 0; i < int'(KEY_BYTES); i++) begin
          if (ptr_q == 8'(i)) key_q[8*i +: 8] <= rx_data;
        end
        for (int i = 0; i < int'(BLK_BYTES); i++) begin
          if (ptr_q == 8'(8'h20 + i)) blk_q[8*i +: 8] <= rx_data;
        end
      end

      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end

      if (stat_rd) done_q <= 1'b0;

      unique case (c_q)
        C_IDLE: begin
          crst_q <= 1'b1;
          if (go) begin
            mode_q <= rx_data[1];
            busy_q <= 1'b1;
            done_q <= 1'b0;
            c_q    <= C_LOAD;
          end
        end
        C_LOAD: begin
          crst_q <= 1'b0;
          c_q    <= C_RUN;
        end
        C_RUN: begin
          if (core_done) begin
            res_q  <= core_result;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            crst_q <= 1'b1;
            c_q    <= C_IDLE;
          end
        end
        default: begin
          crst_q <= 1'b1;
          c_q    <= C_IDLE;
        end
      endcase
    end
  end

  assign rx_ready   = rdy_q;
  assign tx_valid   = bus_addressed & rdy_q;
  assign tx_data    = rd_byte;
  assign core_rst   = crst_q;
  assign core_mode  = mode_q;
  assign core_key   = key_q;
  assign core_block = blk_q;
  assign irq        = done_q;

endmodule
